vga_timing_gen: RTL and testbench

Pixel-timing generator that sits directly upstream of the starfield and other pixel generators. It produces hsync and vsync, the current pixel coordinates, and the active-video flag, plus line and frame strobes. Downstream stages use these to gate their LFSRs and to colour pixels. All outputs are registered and mutually aligned, so a consumer sees every signal for pixel (hpos, vpos) on the same cycle.

---
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Registered VGA pixel-timing generator: sync pulses, coordinates, blanking flags and strobes.
// Defining VGA_FRAME_COUNT_EN adds a 16-bit frame_count output.
module vga_timing_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic H_SYNC_POL = 1'b0,
    parameter logic V_SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    output logic       hsync,
    output logic       vsync,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       display_on,
    output logic       vblank,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
        end
    endgenerate

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_wrap;
    logic       hs_on;
    logic       vs_on;

    // Flags are derived from the next coordinates so they land on the same edge as hpos/vpos.
    always_comb begin
        h_wrap = (hpos == H_LAST);
        h_next = h_wrap ? 10'd0 : hpos + 10'd1;
        v_next = vpos;
        if (h_wrap) begin
            v_next = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
        end
        hs_on = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
        vs_on = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos        <= H_LAST;
            vpos        <= V_LAST;
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            display_on  <= 1'b0;
            vblank      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            hpos        <= h_next;
            vpos        <= v_next;
            hsync       <= hs_on ? H_SYNC_POL : ~H_SYNC_POL;
            vsync       <= vs_on ? V_SYNC_POL : ~V_SYNC_POL;
            display_on  <= (h_next < H_ACT) && (v_next < V_ACT);
            vblank      <= (v_next >= V_ACT);
            line_start  <= (h_next == 10'd0);
            frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    // Counts on the frame_start edge, so the first frame after reset reads 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= 16'd0;
        end else if (ce && h_next == 10'd0 && v_next == 10'd0) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-geometry and a default-geometry instance checked against a
// reference model through a scoreboard queue, with per-phase tallies from a vector table.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic [9:0] hpos;
        logic [9:0] vpos;
        logic       display_on;
        logic       vblank;
        logic       line_start;
        logic       frame_start;
    } out_t;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
    } geom_t;

    typedef struct {
        logic rst;
        int   ce_div;
        int   ncyc;
        int   fs, ls, disp, hsl, vsl, ddisp, dhsl;
    } vec_t;

    logic clk, reset, ce;
    logic       s_hs, s_vs, s_de, s_vb, s_ls, s_fs;
    logic [9:0] s_hp, s_vp;
    logic       d_hs, d_vs, d_de, d_vb, d_ls, d_fs;
    logic [9:0] d_hp, d_vp;
    out_t s_o, d_o;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] s_fc, d_fc;
    logic [15:0] mfs, mfd;
    logic [15:0] qfs[$], qfd[$];
`endif

    assign s_o = {s_hs, s_vs, s_hp, s_vp, s_de, s_vb, s_ls, s_fs};
    assign d_o = {d_hs, d_vs, d_hp, d_vp, d_de, d_vb, d_ls, d_fs};

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4)
    ) dut_s (
        .clk(clk), .reset(reset), .ce(ce),
        .hsync(s_hs), .vsync(s_vs), .hpos(s_hp), .vpos(s_vp),
        .display_on(s_de), .vblank(s_vb), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(s_fc)
`endif
    );

    vga_timing_gen dut_d (
        .clk(clk), .reset(reset), .ce(ce),
        .hsync(d_hs), .vsync(d_vs), .hpos(d_hp), .vpos(d_vp),
        .display_on(d_de), .vblank(d_vb), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(d_fc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    errs, checks, cycn;
    int    t_fs, t_ls, t_disp, t_hsl, t_vsl, t_ddisp, t_dhsl;
    geom_t gs, gd;
    out_t  ms, md;
    out_t  qs[$], qd[$];
    vec_t  tbl[4];

    function automatic out_t rst_val(geom_t g);
        out_t o;
        o.hpos        = 10'(g.ha + g.hf + g.hs + g.hb - 1);
        o.vpos        = 10'(g.va + g.vf + g.vs + g.vb - 1);
        o.hsync       = 1'b1;
        o.vsync       = 1'b1;
        o.display_on  = 1'b0;
        o.vblank      = 1'b1;
        o.line_start  = 1'b0;
        o.frame_start = 1'b0;
        return o;
    endfunction

    function automatic out_t adv(geom_t g, out_t c);
        out_t o;
        int ht, vt, h, v;
        ht = g.ha + g.hf + g.hs + g.hb;
        vt = g.va + g.vf + g.vs + g.vb;
        h  = int'(c.hpos) + 1;
        v  = int'(c.vpos);
        if (h == ht) begin
            h = 0;
            v = v + 1;
            if (v == vt) v = 0;
        end
        o.hpos        = 10'(h);
        o.vpos        = 10'(v);
        o.hsync       = !(h >= g.ha + g.hf && h < g.ha + g.hf + g.hs);
        o.vsync       = !(v >= g.va + g.vf && v < g.va + g.vf + g.vs);
        o.display_on  = (h < g.ha) && (v < g.va);
        o.vblank      = (v >= g.va);
        o.line_start  = (h == 0);
        o.frame_start = (h == 0) && (v == 0);
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, push the model's prediction, pop and compare after the edge.
    task automatic cyc(input logic r, input logic c);
        out_t es, ed;
        @(negedge clk);
        reset = r;
        ce    = c;
        if (r) begin
            ms = rst_val(gs);
            md = rst_val(gd);
        end else if (c) begin
            ms = adv(gs, ms);
            md = adv(gd, md);
        end
        qs.push_back(ms);
        qd.push_back(md);
`ifdef VGA_FRAME_COUNT_EN
        if (r) begin
            mfs = 16'd0;
            mfd = 16'd0;
        end else if (c) begin
            if (ms.frame_start) mfs = mfs + 16'd1;
            if (md.frame_start) mfd = mfd + 16'd1;
        end
        qfs.push_back(mfs);
        qfd.push_back(mfd);
`endif
        @(posedge clk);
        #1;
        cycn++;
        es = qs.pop_front();
        ed = qd.pop_front();
        chk($sformatf("sb_small cyc%0d", cycn), 64'(s_o), 64'(es));
        chk($sformatf("sb_dflt cyc%0d", cycn), 64'(d_o), 64'(ed));
`ifdef VGA_FRAME_COUNT_EN
        chk($sformatf("sb_fc_small cyc%0d", cycn), 64'(s_fc), 64'(qfs.pop_front()));
        chk($sformatf("sb_fc_dflt cyc%0d", cycn), 64'(d_fc), 64'(qfd.pop_front()));
`endif
        t_fs    += int'(s_fs);
        t_ls    += int'(s_ls);
        t_disp  += int'(s_de);
        t_hsl   += int'(!s_hs);
        t_vsl   += int'(!s_vs);
        t_ddisp += int'(d_de);
        t_dhsl  += int'(!d_hs);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        errs = 0; checks = 0; cycn = 0;
        gs = '{16, 4, 8, 4, 12, 2, 2, 4};
        gd = '{640, 16, 96, 48, 480, 10, 2, 33};
        ms = rst_val(gs);
        md = rst_val(gd);
`ifdef VGA_FRAME_COUNT_EN
        mfs = 16'd0;
        mfd = 16'd0;
`endif
        reset = 1'b1;
        ce    = 1'b1;

        // {rst, ce_div, cycles, small: fs ls disp hsync_low vsync_low, default: disp hsync_low}
        tbl[0] = '{1'b1, 1, 5,   0, 0,  0,   0,   0,  0,   0};
        tbl[1] = '{1'b0, 1, 640, 1, 20, 192, 160, 64, 640, 0};
        tbl[2] = '{1'b0, 1, 640, 1, 20, 192, 160, 64, 480, 96};
        tbl[3] = '{1'b0, 4, 128, 4, 4,  64,  32,  0,  128, 0};

        foreach (tbl[k]) begin
            t_fs = 0; t_ls = 0; t_disp = 0; t_hsl = 0; t_vsl = 0; t_ddisp = 0; t_dhsl = 0;
            for (int j = 0; j < tbl[k].ncyc; j++) begin
                cyc(tbl[k].rst, (j % tbl[k].ce_div) == 0);
                if (k == 1 && j == 0) begin
                    chk("first_hpos", 64'(s_hp), 64'd0);
                    chk("first_vpos", 64'(s_vp), 64'd0);
                    chk("first_strobes", 64'({s_fs, s_ls, s_de}), 64'b111);
`ifdef VGA_FRAME_COUNT_EN
                    chk("first_frame_count", 64'(s_fc), 64'd1);
`endif
                end
            end
            chk($sformatf("ph%0d frame_start", k), 64'(t_fs), 64'(tbl[k].fs));
            chk($sformatf("ph%0d line_start", k), 64'(t_ls), 64'(tbl[k].ls));
            chk($sformatf("ph%0d display_on", k), 64'(t_disp), 64'(tbl[k].disp));
            chk($sformatf("ph%0d hsync_low", k), 64'(t_hsl), 64'(tbl[k].hsl));
            chk($sformatf("ph%0d vsync_low", k), 64'(t_vsl), 64'(tbl[k].vsl));
            chk($sformatf("ph%0d dflt_display_on", k), 64'(t_ddisp), 64'(tbl[k].ddisp));
            chk($sformatf("ph%0d dflt_hsync_low", k), 64'(t_dhsl), 64'(tbl[k].dhsl));
            if (k == 0) begin
                chk("rst_dflt_hpos", 64'(d_hp), 64'd799);
                chk("rst_dflt_vpos", 64'(d_vp), 64'd524);
                chk("rst_dflt_flags", 64'({d_hs, d_vs, d_de, d_vb, d_ls, d_fs}), 64'b110100);
            end
        end

`ifdef VGA_FRAME_COUNT_EN
        // Preset the counter to its top value; the next frame_start must wrap it to zero.
        force dut_s.frame_count = 16'hFFFF;
        #1;
        release dut_s.frame_count;
        mfs = 16'hFFFF;
        n = 0;
        do begin
            cyc(1'b0, 1'b1);
            n++;
        end while (!s_fs && n < 1000);
        chk("fc_wrap_reached", 64'(s_fs), 64'd1);
        chk("fc_wrap_value", 64'(s_fc), 64'd0);
`endif

        // Run the small instance to (10,5), then pulse reset between edges.
        n = 0;
        do begin
            cyc(1'b0, 1'b1);
            n++;
        end while (!(s_hp == 10'd10 && s_vp == 10'd5) && n < 1000);
        chk("midframe_reached", 64'({s_hp, s_vp}), 64'({10'd10, 10'd5}));
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_small", 64'(s_o), 64'(rst_val(gs)));
        chk("async_rst_dflt", 64'(d_o), 64'(rst_val(gd)));
        ms = rst_val(gs);
        md = rst_val(gd);
`ifdef VGA_FRAME_COUNT_EN
        mfs = 16'd0;
        mfd = 16'd0;
`endif
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b1);
        chk("restart_pos", 64'({s_hp, s_vp, d_hp, d_vp}), 64'd0);
        chk("restart_frame_start", 64'({s_fs, d_fs}), 64'b11);
        for (int j = 0; j < 40; j++) cyc(1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
